// File: rtl/booth_sequencer.sv
// booth_sequencer: radix-2 Booth multiplier sequencer (8x8 signed -> 16) driving an external add/subtract unit
module booth_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  mcand,
   input  logic [7:0]  mplier,
   output logic [7:0]  as_a,
   output logic [7:0]  as_b,
   output logic        as_cin,
   input  logic [7:0]  as_sum,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;
   logic [7:0] a, q, m, sum_eff;
   logic [8:0] step;
   logic [3:0] count;
   logic q_m1, add, sub, ovf, accept, last;
   always_comb begin
      add = state == CALC && {q[0], q_m1} == 2'b01;
      sub = state == CALC && {q[0], q_m1} == 2'b10;
      // 9th bit recovers the true sign when the 8-bit add/subtract overflows
      ovf = add ? (a[7] == m[7]) && (as_sum[7] != a[7]) :
            sub ? (a[7] != m[7]) && (as_sum[7] != a[7]) : 1'b0;
      sum_eff = (add || sub) ? as_sum : a;
      step = {sum_eff[7] ^ ovf, sum_eff};
      accept = start && state != CALC;
      last = state == CALC && count == 4'd7;
      state_nxt = accept ? CALC : last ? DONE : state == DONE ? IDLE : state;
   end
   always_ff @(posedge clk)
      state <= rst_n ? state_nxt : IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a <= '0;
         q <= '0;
         m <= '0;
         q_m1 <= 1'b0;
         count <= '0;
         product <= '0;
      end else if (accept) begin
         a <= '0;
         q <= mplier;
         m <= mcand;
         q_m1 <= 1'b0;
         count <= '0;
      end else if (state == CALC) begin
         a <= step[8:1];
         q <= {step[0], q[7:1]};
         q_m1 <= q[0];
         count <= count + 4'd1;
         if (last) product <= {step[8:1], step[0], q[7:1]};
      end
   end
   assign as_a = a;
   assign as_b = m;
   assign as_cin = sub;
   assign busy = state == CALC;
   assign done = state == DONE;
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: directed-vector bench for booth_sequencer with a behavioural add/subtract unit
module tb_booth_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, as_cin, busy, done;
   logic [7:0] mcand = '0, mplier = '0, as_a, as_b, as_sum;
   logic [15:0] product;
   int vectors = 0, errs = 0;

   booth_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
      .as_a(as_a), .as_b(as_b), .as_cin(as_cin), .as_sum(as_sum),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;
   assign as_sum = as_cin ? as_a - as_b : as_a + as_b;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [7:0] m, input logic [7:0] q);
      start = 1'b1;
      mcand = m;
      mplier = q;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         cyc();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      mcand = 8'h12;
      mplier = 8'h34;
      cyc();
      cyc();
      vectors++; if ({busy, done, as_cin} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {busy, done, as_cin}); end
      vectors++; if (product !== 16'h0000) begin errs++; $display("FAIL reset_product got %h want 0000", product); end
      vectors++; if ({as_a, as_b} !== 16'h0000) begin errs++; $display("FAIL reset_regs got %h want 0000", {as_a, as_b}); end
      rst_n = 1'b1;
      start = 1'b0;
      cyc();
      vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_start_ignored got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int b = 0;
      start_op(8'd3, 8'd5);
      while (busy && b < 20) begin
         b++;
         cyc();
      end
      vectors++; if (b !== 8) begin errs++; $display("FAIL basic_busy_cycles got %0d want 8", b); end
      vectors++; if (done !== 1'b1) begin errs++; $display("FAIL basic_done got %b want 1", done); end
      vectors++; if (product !== 16'h000F) begin errs++; $display("FAIL basic_product got %h want 000F", product); end
      cyc();
      vectors++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL basic_done_pulse got %b want 00", {busy, done}); end
      vectors++; if (product !== 16'h000F) begin errs++; $display("FAIL basic_hold got %h want 000F", product); end
   endtask

   task automatic test_neg();
      int n;
      start_op(8'hF9, 8'h06);
      vectors++; if (product !== 16'h000F) begin errs++; $display("FAIL neg_product_on_accept got %h want 000F", product); end
      vectors++; if (as_b !== 8'hF9) begin errs++; $display("FAIL neg_as_b got %h want F9", as_b); end
      vectors++; if (as_cin !== 1'b0) begin errs++; $display("FAIL neg_cin_step1 got %b want 0", as_cin); end
      cyc();
      vectors++; if (as_cin !== 1'b1) begin errs++; $display("FAIL neg_cin_step2 got %b want 1", as_cin); end
      vectors++; if (product !== 16'h000F) begin errs++; $display("FAIL neg_product_in_calc got %h want 000F", product); end
      wait_done(n);
      vectors++; if (n !== 7) begin errs++; $display("FAIL neg_latency got %0d want 7", n); end
      vectors++; if (product !== 16'hFFD6) begin errs++; $display("FAIL neg_product got %h want FFD6", product); end
      vectors++; if (as_cin !== 1'b0) begin errs++; $display("FAIL neg_cin_done got %b want 0", as_cin); end
   endtask

   task automatic test_extremes();
      int n;
      start_op(8'h80, 8'h80);
      wait_done(n);
      vectors++; if (product !== 16'h4000) begin errs++; $display("FAIL ext_min_min got %h want 4000", product); end
      start_op(8'h7F, 8'h80);
      vectors++; if (busy !== 1'b1) begin errs++; $display("FAIL ext_back_to_back got %b want 1", busy); end
      wait_done(n);
      vectors++; if (n !== 8) begin errs++; $display("FAIL ext_latency got %0d want 8", n); end
      vectors++; if (product !== 16'hC080) begin errs++; $display("FAIL ext_max_min got %h want C080", product); end
      cyc();
   endtask

   task automatic test_start_ignored();
      int d = 0;
      logic [15:0] p = '0;
      start_op(8'h0B, 8'h0D);
      cyc();
      cyc();
      start_op(8'h55, 8'h66);
      cyc();
      start_op(8'hAA, 8'h77);
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            d++;
            p = product;
         end
         cyc();
      end
      vectors++; if (d !== 1) begin errs++; $display("FAIL ignore_done_count got %0d want 1", d); end
      vectors++; if (p !== 16'h008F) begin errs++; $display("FAIL ignore_product got %h want 008F", p); end
   endtask

   task automatic test_reset_abort();
      int d = 0, n;
      start_op(8'h11, 8'h22);
      cyc();
      cyc();
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", busy); end
      vectors++; if (product !== 16'h0000) begin errs++; $display("FAIL abort_product got %h want 0000", product); end
      for (int i = 0; i < 12; i++) begin
         if (done) d++;
         cyc();
      end
      vectors++; if (d !== 0) begin errs++; $display("FAIL abort_done_count got %0d want 0", d); end
      vectors++; if (product !== 16'h0000) begin errs++; $display("FAIL abort_product_hold got %h want 0000", product); end
      start_op(8'h02, 8'hFF);
      wait_done(n);
      vectors++; if (product !== 16'hFFFE) begin errs++; $display("FAIL abort_fresh got %h want FFFE", product); end
   endtask

   task automatic test_sweep();
      logic [7:0] corner [8] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'hFE, 8'h40};
      logic [7:0] m, q;
      logic signed [15:0] expv;
      int n;
      for (int k = 0; k < 664; k++) begin
         if (k < 64) begin
            m = corner[k / 8];
            q = corner[k % 8];
         end else begin
            m = 8'($urandom_range(255));
            q = 8'($urandom_range(255));
         end
         expv = $signed(m) * $signed(q);
         start_op(m, q);
         wait_done(n);
         vectors++; if (done !== 1'b1 || product !== expv) begin errs++; $display("FAIL sweep %h*%h got %h want %h", m, q, product, expv); end
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_neg();
      test_extremes();
      test_start_ignored();
      test_reset_abort();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
